// File: rtl/tri2d_mul_arb.sv
// Round-robin arbiter sharing one 3-stage 14x5 multiplier among N_REQ requesters.
// Define TRI2D_MUL_ARB_STATS_EN to add the stat_issue/stat_stall counters.
module tri2d_mul_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*14-1:0]   req_a,
    input  logic [N_REQ*5-1:0]    req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  mul_ce,
    output logic [13:0]           mul_din0,
    output logic [4:0]            mul_din1,
    input  logic [16:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [16:0]           rsp_data,
    output logic                  idle
`ifdef TRI2D_MUL_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issue,
    output logic [31:0]           stat_stall
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   winner;
    logic              grant_any;
    logic [MUL_LAT-1:0] tag_valid;
    logic [ID_W-1:0]   tag_id [MUL_LAT];

    // The tag pipeline mirrors the multiplier stages, so its last stage qualifies mul_dout.
    assign rsp_valid = tag_valid[MUL_LAT-1];
    assign rsp_id    = tag_id[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign mul_ce    = !(rsp_valid && !rsp_ready);
    assign idle      = (state == IDLE) && (tag_valid == '0);

    // Two passes: first look at or above the pointer, then wrap to the lowest index.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (mul_ce && state == RUN) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!grant_any && req_valid[j] && (ID_W'(j) >= ptr)) begin
                    grant_any = 1'b1;
                    winner    = ID_W'(j);
                end
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!grant_any && req_valid[j]) begin
                    grant_any = 1'b1;
                    winner    = ID_W'(j);
                end
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (grant_any && winner == ID_W'(j)) begin
                    req_ready[j] = 1'b1;
                    mul_din0     = req_a[j*14 +: 14];
                    mul_din1     = req_b[j*5 +: 5];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (en)
                    state_next = RUN;
                else if (tag_valid == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (grant_any)
                ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Shifts only on mul_ce so the tags stay aligned with the stalled multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            for (int s = 0; s < MUL_LAT; s++)
                tag_id[s] <= '0;
        end else if (mul_ce) begin
            tag_valid <= {tag_valid[MUL_LAT-2:0], grant_any};
            tag_id[0] <= winner;
            for (int s = 1; s < MUL_LAT; s++)
                tag_id[s] <= tag_id[s-1];
        end
    end

`ifdef TRI2D_MUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (grant_any)
                stat_issue <= stat_issue + 32'd1;
            if (!mul_ce)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tri2d_mul_arb.sv
// Directed self-checking bench for tri2d_mul_arb with a behavioural 3-stage multiplier.
module tb_tri2d_mul_arb;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N*14-1:0]   req_a;
    logic [N*5-1:0]    req_b;
    logic [N-1:0]      req_ready;
    logic              mul_ce;
    logic [13:0]       mul_din0;
    logic [4:0]        mul_din1;
    logic [16:0]       mul_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [16:0]       rsp_data;
    logic              idle;
`ifdef TRI2D_MUL_ARB_STATS_EN
    logic [31:0]       stat_issue;
    logic [31:0]       stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [16:0] p0, p1, p2;

    always #5 clk = ~clk;

    // Multiplier model: no reset, advances only when enabled.
    always @(posedge clk) begin
        if (mul_ce) begin
            p0 <= {3'b0, mul_din0} * {12'b0, mul_din1};
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign mul_dout = p2;

    tri2d_mul_arb #(.N_REQ(N), .ID_W(2), .MUL_LAT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .idle      (idle)
`ifdef TRI2D_MUL_ARB_STATS_EN
        ,
        .stat_issue(stat_issue),
        .stat_stall(stat_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b);
        req_a[id*14 +: 14] = 14'(a);
        req_b[id*5 +: 5]   = 5'(b);
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick; tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0d, expected 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b, expected 0000", req_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %0d, expected 1", idle); end
        checks++; if (mul_ce !== 1'b1) begin errors++; $display("[TB] FAIL reset_mul_ce: got %0d, expected 1", mul_ce); end
        reset = 1'b1;
        tick;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL idle_en_low: got %0d, expected 1", idle); end
    endtask

    task automatic test_round_robin;
        int bv[4] = '{3, 8, 13, 31};
        int exp_id[$];
        int exp_dat[$];
        int got = 0;
        logic exp_v;
        for (int i = 0; i < N; i++) set_op(i, 1000 * (i + 1) + i, bv[i]);
        en = 1'b1;
        tick;
        checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL run_idle: got %0d, expected 0", idle); end
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            exp_v = (c >= 3 && c <= 10);
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("[TB] FAIL rr_rsp_valid c=%0d: got %0d, expected %0d", c, rsp_valid, exp_v); end
            if (rsp_valid === 1'b1) begin
                if (exp_id.size() == 0) begin
                    checks++; errors++; $display("[TB] FAIL rr_extra_rsp: got id %0d, expected none", rsp_id);
                end else begin
                    int ei, ed;
                    ei = exp_id.pop_front();
                    ed = exp_dat.pop_front();
                    got++;
                    checks++; if (rsp_id !== 2'(ei)) begin errors++; $display("[TB] FAIL rr_rsp_id: got %0d, expected %0d", rsp_id, ei); end
                    checks++; if (rsp_data !== 17'(ed)) begin errors++; $display("[TB] FAIL rr_rsp_data: got %0d, expected %0d", rsp_data, ed); end
                end
            end
            if (c < 8) begin
                logic [3:0] eg;
                eg = 4'(1 << (c % 4));
                checks++; if (req_ready !== eg) begin errors++; $display("[TB] FAIL rr_grant c=%0d: got %b, expected %b", c, req_ready, eg); end
                exp_id.push_back(c % 4);
                exp_dat.push_back(((1000 * (c % 4 + 1) + c % 4) * bv[c % 4]) % 131072);
            end
            tick;
        end
        checks++; if (got != 8) begin errors++; $display("[TB] FAIL rr_rsp_count: got %0d, expected 8", got); end
    endtask

    task automatic test_single;
        set_op(2, 100, 7);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b, expected 0100", req_ready); end
        checks++; if (mul_din0 !== 14'd100) begin errors++; $display("[TB] FAIL single_din0: got %0d, expected 100", mul_din0); end
        checks++; if (mul_din1 !== 5'd7) begin errors++; $display("[TB] FAIL single_din1: got %0d, expected 7", mul_din1); end
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early1: got %0d, expected 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early2: got %0d, expected 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0d, expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id: got %0d, expected 2", rsp_id); end
        checks++; if (rsp_data !== 17'd700) begin errors++; $display("[TB] FAIL single_data: got %0d, expected 700", rsp_data); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_dup: got %0d, expected 0", rsp_valid); end
    endtask

    task automatic test_truncation;
        set_op(0, 16383, 31);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL trunc_grant: got %b, expected 0001", req_ready); end
        tick;
        req_valid = '0;
        tick; tick;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL trunc_valid: got %0d, expected 1", rsp_valid); end
        checks++; if (rsp_data !== 17'd114657) begin errors++; $display("[TB] FAIL trunc_data: got %0d, expected 114657", rsp_data); end
        tick;
    endtask

    task automatic test_backpressure;
        int ids[3]  = '{0, 1, 3};
        int dats[3] = '{63, 10000, 21928};
        rsp_ready = 1'b0;
        set_op(0, 21, 3);
        set_op(1, 500, 20);
        set_op(3, 9000, 17);
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eg;
            eg = 4'(1 << ids[k]);
            req_valid = eg;
            #1;
            checks++; if (req_ready !== eg) begin errors++; $display("[TB] FAIL bp_grant k=%0d: got %b, expected %b", k, req_ready, eg); end
            tick;
        end
        set_op(2, 1, 1);
        req_valid = 4'b0100;
        #1;
        for (int h = 0; h < 4; h++) begin
            checks++; if (mul_ce !== 1'b0) begin errors++; $display("[TB] FAIL bp_ce h=%0d: got %0d, expected 0", h, mul_ce); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready h=%0d: got %b, expected 0000", h, req_ready); end
            checks++; if (rsp_data !== 17'd63) begin errors++; $display("[TB] FAIL bp_hold_data h=%0d: got %0d, expected 63", h, rsp_data); end
            tick;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        for (int r = 0; r < 3; r++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rel_valid r=%0d: got %0d, expected 1", r, rsp_valid); end
            checks++; if (rsp_id !== 2'(ids[r])) begin errors++; $display("[TB] FAIL bp_rel_id r=%0d: got %0d, expected %0d", r, rsp_id, ids[r]); end
            checks++; if (rsp_data !== 17'(dats[r])) begin errors++; $display("[TB] FAIL bp_rel_data r=%0d: got %0d, expected %0d", r, rsp_data, dats[r]); end
            tick;
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %0d, expected 0", rsp_valid); end
`ifdef TRI2D_MUL_ARB_STATS_EN
        checks++; if (stat_stall !== 32'd4) begin errors++; $display("[TB] FAIL stat_stall: got %0d, expected 4", stat_stall); end
        checks++; if (stat_issue !== 32'd13) begin errors++; $display("[TB] FAIL stat_issue: got %0d, expected 13", stat_issue); end
`endif
    endtask

    task automatic test_drain;
        set_op(0, 12, 12);
        set_op(1, 77, 2);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL drain_grant0: got %b, expected 0001", req_ready); end
        tick;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL drain_grant1: got %b, expected 0010", req_ready); end
        tick;
        req_valid = '0;
        en = 1'b0;
        tick;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drain_no_grant: got %b, expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 17'd144) begin errors++; $display("[TB] FAIL drain_rsp0: got v=%0d id=%0d d=%0d, expected v=1 id=0 d=144", rsp_valid, rsp_id, rsp_data); end
        tick;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drain_no_grant2: got %b, expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 17'd154) begin errors++; $display("[TB] FAIL drain_rsp1: got v=%0d id=%0d d=%0d, expected v=1 id=1 d=154", rsp_valid, rsp_id, rsp_data); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %0d, expected 0", rsp_valid); end
        checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle_early: got %0d, expected 0", idle); end
        tick;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL drain_idle: got %0d, expected 1", idle); end
        req_valid = '0;
    endtask

    task automatic test_reset_midstream;
        en = 1'b1;
        tick;
        for (int i = 0; i < N; i++) set_op(i, 7 + i, 2 + i);
        req_valid = 4'hF;
        tick; tick; tick; tick;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid: got %0d, expected 1", rsp_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp_valid: got %0d, expected 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL mid_req_ready: got %b, expected 0000", req_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle: got %0d, expected 1", idle); end
        tick; tick;
        reset = 1'b1;
        req_valid = '0;
        tick;
        set_op(1, 3, 4);
        set_op(3, 5, 5);
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL mid_ptr_restart: got %b, expected 0010", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale0: got %0d, expected 0", rsp_valid); end
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale1: got %0d, expected 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale2: got %0d, expected 0", rsp_valid); end
        tick;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 17'd12) begin errors++; $display("[TB] FAIL mid_rsp: got v=%0d id=%0d d=%0d, expected v=1 id=1 d=12", rsp_valid, rsp_id, rsp_data); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after: got %0d, expected 0", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_truncation;
        test_backpressure;
        test_drain;
        test_reset_midstream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tri2d_mul_arb.md
Name: tri2d_mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 14x5 unsigned multiplier (3-cycle latency, clock-enable stalled, no reset) among N requesters in the tri2d datapath.
- Grants one operand pair per cycle to the multiplier and drives its ce.
- Tracks requester IDs through a tag pipeline aligned with the multiplier stages.
- Returns each 17-bit product with its ID on a single valid/ready response port.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester-ID width, equals clog2(N_REQ)
- MUL_LAT, 3, multiplier latency in enabled clock edges from operand presentation to dout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  1 = accept new requests; 0 = drain and stop granting
- req_valid  in  N_REQ  per-requester operand valid
- req_a  in  N_REQ*14  operand a, requester i at bits [14i+13:14i]
- req_b  in  N_REQ*5  operand b, requester i at bits [5i+4:5i]
- req_ready  out  N_REQ  one-hot grant; handshake completes when valid & ready
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  14  operand a to multiplier
- mul_din1  out  5  operand b to multiplier
- mul_dout  in  17  multiplier product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  17  product: low 17 bits of a*b, unsigned, truncated
- idle  out  1  no request in flight and state IDLE

Behaviour:
- Reset (reset=0, asynchronous): tag valid bits 0, rr pointer 0, state IDLE, rsp_valid 0, req_ready 0, idle 1. Multiplier data is undefined after reset; only the tag valid bits qualify it.
- Stall rule: mul_ce = !(rsp_valid & !rsp_ready). When mul_ce is 0, the tag pipeline holds, no grant is issued, and req_ready is all 0.
- Grant (combinational):
  - Issued when mul_ce=1, state RUN and any req_valid is set.
  - Chooses the first set req_valid at or after the rr pointer, wrapping modulo N_REQ.
  - req_ready has exactly that bit set.
  - mul_din0/mul_din1 carry the winner's operands; otherwise they are 0.
- Pointer update: on a granted edge the pointer becomes (winner+1) mod N_REQ; it is unchanged otherwise.
- Tag pipeline:
  - MUL_LAT stages of {valid, id}; stage 0 loads {grant_any, winner} on each mul_ce edge, and each stage shifts on mul_ce.
  - rsp_valid/rsp_id are the last stage; rsp_data = mul_dout.
  - Latency is grant edge to rsp_valid = MUL_LAT edges with no stall.
  - Throughput is 1 per cycle.
- Simultaneous accept and new issue in the same cycle are allowed (pipeline advances). A bubble (valid 0) in the last stage never blocks.
- FSM:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0; in DRAIN there are no grants.
  - DRAIN -> IDLE when all tag valids are 0; DRAIN -> RUN if en returns to 1.
  - IDLE with en=0 stays IDLE.
- idle = (state IDLE) & no tag valid.
- Requester deasserting req_valid without a grant is legal and drops out of arbitration.
- Asynchronous reset mid-operation: in-flight results are discarded and no response is emitted for them.

Optional Feature:
- Macro TRI2D_MUL_ARB_STATS_EN.
- Defined: adds outputs stat_issue (32 bits, granted handshakes) and stat_stall (32 bits, cycles with mul_ce=0). Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request, N_REQ=4, en=1: req 2 with a=100, b=7 -> req_ready=0100 same cycle; rsp_valid exactly 3 edges later with rsp_id=2, rsp_data=700.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses in the same order, 1 per cycle.
- Truncation: a=16383, b=31 -> rsp_data = 507873 mod 131072 = 114657.
- Backpressure: hold rsp_ready=0 while 3 requests are in flight -> mul_ce=0, req_ready=0, rsp_data stable. On release, the 3 responses arrive on consecutive cycles with none lost or duplicated. stat_stall counts the held cycles (with macro).
- Drain: en dropped with 2 in flight -> no new grants, both responses delivered, idle=1 one cycle after the last tag clears.
- Async reset asserted mid-stream -> rsp_valid, req_ready 0 immediately. After release, a request to id 1 (a=3, b=4) returns 12 with the pointer having restarted at 0.
